// File: rtl/spi_slave_pkg.sv
// Shared types and protocol constants for the SPI slave register-file device.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WADDR,
        WDATA,
        RADDR,
        RDATA,
        ID,
        IGNORE
    } spi_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_ID    = 8'h9F;
    localparam logic [7:0] ID_BYTE   = 8'hA5;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with rise/fall detection
// taken between the last synchronized stage and one extra delay flop.
module spi_in_sync
    import spi_slave_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sr;
    logic                   dly;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr  <= {SYNC_STAGES{RST_VAL}};
            dly <= RST_VAL;
        end else begin
            sr[0] <= pin;
            for (int i = 1; i < SYNC_STAGES; i++) sr[i] <= sr[i-1];
            dly <= sr[SYNC_STAGES-1];
        end
    end

    assign level = sr[SYNC_STAGES-1];
    assign rise  = level & ~dly;
    assign fall  = ~level & dly;

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave exposing a small byte-addressable memory through a
// write / read / ID command protocol, oversampled in the system clock domain.
module spi_slave_mem
    import spi_slave_pkg::*;
#(
    parameter int MEM_DEPTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    spi_state_t    state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx;
    logic [7:0]    tx;
    logic [AW-1:0] addr;
    logic          miso_bit;
    logic [7:0]    mem [MEM_DEPTH];

    logic cs_q, cs_rise, cs_fall;
    logic sclk_q, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic sync_unused;

    logic          byte_done;
    logic          shifting;
    logic [7:0]    rx_next;
    logic [AW-1:0] raddr;
    logic [AW-1:0] addr_inc;

    // cs_n idles high, so its synchronizer resets to 1 to avoid a false fall.
    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clock (clock),
        .reset (reset),
        .pin   (cs_n),
        .level (cs_q),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clock (clock),
        .reset (reset),
        .pin   (sclk),
        .level (sclk_q),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clock (clock),
        .reset (reset),
        .pin   (mosi),
        .level (mosi_q),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign sync_unused = ^{sclk_q, mosi_rise, mosi_fall};

    // Gating on state rather than cs_q keeps a byte that completes on the
    // same cycle as the cs_n rise, so a final WDATA byte still commits.
    assign byte_done = sclk_rise && (state_q != IDLE) && (bit_cnt == 3'd7);
    assign shifting  = (state_q == RDATA) || (state_q == ID);
    assign rx_next   = {rx[6:0], mosi_q};
    assign raddr     = rx_next[AW-1:0];
    assign addr_inc  = addr + AW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (cs_fall) state_d = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (rx_next)
                            CMD_WRITE: state_d = WADDR;
                            CMD_READ:  state_d = RADDR;
                            CMD_ID:    state_d = ID;
                            default:   state_d = IGNORE;
                        endcase
                    end
                end
                WADDR: if (byte_done) state_d = WDATA;
                RADDR: if (byte_done) state_d = RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            addr      <= '0;
            miso_bit  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= 1'b0;

            if (sclk_rise && state_q != IDLE) begin
                rx      <= rx_next;
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
                case (state_q)
                    CMD:   if (rx_next == CMD_ID) tx <= ID_BYTE;
                    WADDR: addr <= raddr;
                    WDATA: begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= 8'(addr);
                        wr_data   <= rx_next;
                        addr      <= addr_inc;
                    end
                    RADDR: begin
                        addr <= raddr;
                        tx   <= mem[raddr];
                    end
                    RDATA: begin
                        addr <= addr_inc;
                        tx   <= mem[addr_inc];
                    end
                    // The single ID byte is done; shift zeros until deselect.
                    ID:    tx <= '0;
                    default: ;
                endcase
            end

            if (shifting && sclk_fall) begin
                miso_bit <= tx[7];
                tx       <= {tx[6:0], 1'b0};
            end else if (!shifting) begin
                miso_bit <= 1'b0;
            end

            // A deselect drops any partial byte and silences miso.
            if (cs_rise || cs_fall) bit_cnt <= '0;
            if (cs_rise) miso_bit <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (byte_done && state_q == WDATA) begin
            mem[addr] <= rx_next;
        end
    end

    assign miso    = miso_bit;
    assign miso_oe = ~cs_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_mem.sv
// Bit-banged SPI master driving spi_slave_mem; expected read bytes and write
// strobes are queued by the stimulus and checked by an independent monitor.
module tb_spi_slave_mem;

    localparam int HALF = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_rd[$];
    logic [15:0] exp_wr[$];
    logic        rd_pulse = 1'b0;
    logic [7:0]  rd_byte  = '0;
    logic        watch_zero = 1'b0;
    int          zero_viol  = 0;

    spi_slave_mem #(.MEM_DEPTH(16), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: consumes queued expectations whenever the DUT or master presents data.
    always @(negedge clock) begin
        if (watch_zero && miso !== 1'b0) zero_viol++;
        if (rd_pulse) begin
            if (exp_rd.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_unexpected: got %h expected none", rd_byte);
            end else begin
                check("rd_byte", 32'(rd_byte), 32'(exp_rd.pop_front()));
            end
        end
        if (wr_strobe === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL wr_unexpected: got addr %h data %h expected none", wr_addr, wr_data);
            end else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[15:8]));
                check("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nb, input bit cap);
        logic [7:0] got;
        got = '0;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi = b[i];
            tick(HALF);
            @(negedge clock);
            got[i] = miso;
            @(posedge clock);
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
        if (cap) begin
            rd_byte  = got;
            rd_pulse = 1'b1;
            @(posedge clock);
            rd_pulse = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8, 1'b0);
    endtask

    task automatic spi_read(input logic [7:0] expv);
        exp_rd.push_back(expv);
        spi_bits(8'h00, 8, 1'b1);
    endtask

    task automatic spi_begin;
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic spi_end;
        tick(HALF);
        cs_n = 1'b1;
        tick(8);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tick(3);
        @(negedge clock);
        check("rst_miso",      32'(miso),      0);
        check("rst_miso_oe",   32'(miso_oe),   0);
        check("rst_wr_strobe", 32'(wr_strobe), 0);
        check("rst_wr_addr",   32'(wr_addr),   0);
        check("rst_wr_data",   32'(wr_data),   0);
        check("rst_busy",      32'(busy),      0);
        reset = 1'b1;
        tick(4);

        // ID command: A5 once, then zeros until deselect
        spi_begin();
        spi_byte(8'h9F);
        check("id_busy", 32'(busy), 1);
        check("id_oe",   32'(miso_oe), 1);
        spi_read(8'hA5);
        spi_read(8'h00);
        spi_end();
        check("id_busy_after", 32'(busy), 0);

        // Write two bytes at 5, read back
        exp_wr.push_back({8'h05, 8'h11});
        exp_wr.push_back({8'h06, 8'h22});
        spi_begin(); spi_byte(8'h02); spi_byte(8'h05); spi_byte(8'h11); spi_byte(8'h22); spi_end();
        spi_begin(); spi_byte(8'h03); spi_byte(8'h05); spi_read(8'h11); spi_read(8'h22); spi_end();

        // Address wrap on write and on read
        exp_wr.push_back({8'h0F, 8'hAA});
        exp_wr.push_back({8'h00, 8'hBB});
        spi_begin(); spi_byte(8'h02); spi_byte(8'h0F); spi_byte(8'hAA); spi_byte(8'hBB); spi_end();
        spi_begin(); spi_byte(8'h03); spi_byte(8'h0F); spi_read(8'hAA); spi_read(8'hBB); spi_read(8'h00); spi_end();

        // Partial data byte aborted by cs_n: no write
        spi_begin(); spi_byte(8'h02); spi_byte(8'h03); spi_bits(8'hF0, 4, 1'b0); spi_end();
        spi_begin(); spi_byte(8'h03); spi_byte(8'h03); spi_read(8'h00); spi_end();

        // Unknown command: miso held low throughout
        zero_viol = 0;
        spi_begin();
        watch_zero = 1'b1;
        spi_byte(8'h7E); spi_byte(8'hFF); spi_byte(8'h55);
        check("ign_busy", 32'(busy), 1);
        spi_end();
        watch_zero = 1'b0;
        check("ign_miso_zero", 32'(zero_viol), 0);
        check("ign_busy_after", 32'(busy), 0);

        // sclk activity while deselected must not disturb framing
        mosi = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sclk = 1'b1; tick(HALF); sclk = 1'b0; tick(HALF);
        end
        check("desel_busy", 32'(busy), 0);
        exp_wr.push_back({8'h07, 8'h3C});
        spi_begin(); spi_byte(8'h02); spi_byte(8'h07); spi_byte(8'h3C); spi_end();
        spi_begin(); spi_byte(8'h03); spi_byte(8'h07); spi_read(8'h3C); spi_end();

        // Reset mid-WDATA after a committed write
        exp_wr.push_back({8'h09, 8'h5C});
        spi_begin(); spi_byte(8'h02); spi_byte(8'h09); spi_byte(8'h5C);
        spi_bits(8'hFF, 4, 1'b0);
        tick(2);
        reset = 1'b0;
        #1;
        check("mid_rst_miso",      32'(miso),      0);
        check("mid_rst_miso_oe",   32'(miso_oe),   0);
        check("mid_rst_wr_strobe", 32'(wr_strobe), 0);
        check("mid_rst_wr_addr",   32'(wr_addr),   0);
        check("mid_rst_wr_data",   32'(wr_data),   0);
        check("mid_rst_busy",      32'(busy),      0);
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(4);
        spi_begin(); spi_byte(8'h03); spi_byte(8'h09); spi_read(8'h00); spi_end();

        tick(4);
        check("wr_queue_drained", 32'(exp_wr.size()), 0);
        check("rd_queue_drained", 32'(exp_rd.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_mem.md
Name: spi_slave_mem

Overview:
- Synthesisable SPI slave register-file device, mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits directly downstream of the SoC's SPI1 master on the GPIO pads:
  - gpio[20] drives ss0, which is cs_n here.
  - gpio[21] drives sclk.
  - gpio[23] drives mosi.
  - gpio[22] receives miso.
- Oversamples the SPI pins in the system clock domain, decodes a byte-oriented command protocol, and provides a small byte-addressable memory the firmware reads and writes through the SPI master.
- Also exposes write-observation strobes for scoreboarding.

Parameters:
- MEM_DEPTH, 16: number of 8-bit storage locations. Must be a power of 2, maximum 256. Addresses wrap modulo MEM_DEPTH.
- SYNC_STAGES, 2: flip-flop stages in the input synchronizers.

Ports:
- clock  input  1  system clock; all logic runs on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cs_n  input  1  SPI chip select, active low, asynchronous to clock.
- sclk  input  1  SPI serial clock, asynchronous to clock.
- mosi  input  1  SPI data from master.
- miso  output  1  SPI data to master.
- miso_oe  output  1  miso output enable; high while the synchronized cs_n is low.
- wr_strobe  output  1  one-cycle pulse when a byte is committed to memory.
- wr_addr  output  8  address of the committed byte; valid with wr_strobe.
- wr_data  output  8  committed byte; valid with wr_strobe.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - All memory locations are 0x00. State is IDLE. Bit counter is 0. Address register is 0.
  - miso=0, miso_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
- Input conditioning:
  - cs_n, sclk and mosi each pass through SYNC_STAGES flip-flops.
  - Rising and falling edges of sclk, and the falling and rising edges of cs_n, are detected from the last synchronized stage and the stage after it.
  - Edge-to-action latency is SYNC_STAGES+1 clocks.
  - Legal SPI timing: sclk high time and sclk low time are each at least 4 clocks; cs_n setup before the first sclk rise is at least 4 clocks.
- Sampling and driving:
  - mosi is sampled into the rx shift register on each detected sclk rising edge.
  - miso is updated on each detected sclk falling edge.
  - A 3-bit counter counts rising edges; on its wrap from 7 to 0 a byte is complete.
- States (shared enum):
  - IDLE: entered on reset or any cs_n rise. On a cs_n fall, go to CMD with the bit counter at 0.
  - CMD: on byte complete:
    - 0x02 goes to WADDR.
    - 0x03 goes to RADDR.
    - 0x9F goes to ID.
    - Anything else goes to IGNORE.
  - WADDR: on byte complete, addr is loaded from rx[log2(MEM_DEPTH)-1:0] and the state goes to WDATA.
  - WDATA: on each byte complete:
    - mem[addr] is written with rx.
    - wr_strobe=1 for one clock, with wr_addr=addr and wr_data=rx.
    - addr is incremented with wrap (MEM_DEPTH-1 goes to 0).
  - RADDR: on byte complete, addr is loaded, tx is loaded with mem[addr], and the state goes to RDATA.
  - RDATA:
    - Each falling edge shifts tx out MSB first, so tx[7] appears on miso at the first falling edge after the byte-complete rise.
    - On each byte complete, addr is incremented with wrap and tx is reloaded with mem[new addr].
  - ID: tx is loaded with the constant 0xA5 on byte complete of CMD and shifted out like RDATA. After one byte, miso=0 until cs_n rises.
  - IGNORE: rx is discarded and miso=0 until cs_n rises.
- miso is 0 in every state except RDATA and ID.
- Boundary conditions:
  - cs_n rises mid-byte: the partial byte is discarded with no memory write and no wr_strobe, the state returns to IDLE, and miso goes to 0.
  - cs_n rise coincides with byte complete in WDATA: the write commits and then the state goes to IDLE.
  - Reset mid-transaction: immediate return to reset values, including memory.
  - Address wrap: the read or write after MEM_DEPTH-1 accesses address 0.
  - sclk edges while cs_n is high are ignored.
  - A read immediately after a write to the same address returns the new data; the write commits before any later load.

Decomposition:
- spi_slave_pkg holds:
  - the state enum typedef: IDLE, CMD, WADDR, WDATA, RADDR, RDATA, ID, IGNORE;
  - command constants CMD_WRITE=8'h02, CMD_READ=8'h03, CMD_ID=8'h9F;
  - the constant ID_BYTE=8'hA5.
- Sub-module spi_in_sync, instantiated once per pin: parameterised synchronizer plus rise/fall edge detector.

Test Plan:
- After reset: send 0x9F, then 8 dummy clocks -> miso returns 0xA5; busy=1 during the frame and 0 after cs_n rises.
- Write 0x02, 0x05, 0x11, 0x22 -> wr_strobe pulses twice: (addr 5, data 0x11) then (addr 6, data 0x22). A following read 0x03, 0x05, plus 2 bytes returns 0x11, 0x22.
- Write 0x02, 0x0F, 0xAA, 0xBB with MEM_DEPTH=16 -> mem[15]=0xAA and mem[0]=0xBB. Reading from 0x0F for 2 bytes returns 0xAA, 0xBB.
- Write 0x02, 0x03, then 4 bits of 0xF0, then raise cs_n -> no wr_strobe; a read of addr 3 returns 0x00.
- Send unknown command 0x7E, then 2 more bytes -> state is IGNORE, miso stays 0 throughout, no wr_strobe, and the state is IDLE after cs_n rises.
- Assert reset low mid-way through a WDATA byte after a prior committed write -> all outputs are at reset values within the same clock, and a read of the previously written address returns 0x00.
